// File: rtl/xadc_drp_responder_if.sv
// -----------------------------------------------------------------------------
// xadc_drp_responder_if
// DRP bus bundle between the sensor-readout logic (master) and the XADC
// stand-in (slave).
//   daddr_in  [6:0]  DRP address               master -> slave
//   den_in           1-cycle enable strobe     master -> slave
//   dwe_in           write enable (with den)   master -> slave
//   di_in    [15:0]  write data                master -> slave
//   do_out   [15:0]  read data (with drdy)     slave  -> master
//   drdy_out         completion pulse          slave  -> master
// -----------------------------------------------------------------------------
interface xadc_drp_responder_if;
   logic [6:0]  daddr_in;
   logic        den_in;
   logic        dwe_in;
   logic [15:0] di_in;
   logic [15:0] do_out;
   logic        drdy_out;

   modport master (
      output daddr_in, den_in, dwe_in, di_in,
      input  do_out, drdy_out
   );

   modport slave (
      input  daddr_in, den_in, dwe_in, di_in,
      output do_out, drdy_out
   );
endinterface

// File: rtl/xadc_drp_responder.sv
// -----------------------------------------------------------------------------
// xadc_drp_responder
// Synthesizable XADC stand-in answering DRP accesses and sequencing
// alternating ch22 / ch30 conversions that produce deterministic ramp samples.
//
// Parameters:
//   CONV_CYCLES  busy cycles per conversion (>= 2)
//   DRDY_LAT     cycles from accepted den_in to drdy_out (1..15)
//   RAMP_STEP    per-conversion sample increment (low nibble zero)
// Ports:
//   CLK100MHZ    sole clock (DRP clock)
//   CPU_RESETN   synchronous active-low reset
//   drp          DRP slave bundle (daddr/den/dwe/di in, do/drdy out)
//   busy_out     conversion in progress
//   eoc_out      end-of-conversion pulse
//   eos_out      end-of-sequence pulse (after ch30)
//   channel_out  channel of the latest conversion
//   drp_err_out  sticky: den_in seen while a transaction was pending
// Optional feature:
//   XADC_RESP_NOISE_EN  XORs LFSR dither into sample bits [7:4]
// -----------------------------------------------------------------------------
module xadc_drp_responder #(
   parameter int unsigned CONV_CYCLES = 26,
   parameter int unsigned DRDY_LAT    = 4,
   parameter logic [15:0] RAMP_STEP   = 16'h0010
) (
   input  logic                 CLK100MHZ,
   input  logic                 CPU_RESETN,
   xadc_drp_responder_if.slave  drp,
   output logic                 busy_out,
   output logic                 eoc_out,
   output logic                 eos_out,
   output logic [4:0]           channel_out,
   output logic                 drp_err_out
);

   localparam int unsigned CW       = $clog2(CONV_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(CONV_CYCLES - 1);
   localparam logic [3:0]  LAT_LAST = 4'(DRDY_LAT - 1);

   typedef enum logic {S_CONV, S_EOC}  seq_t;
   typedef enum logic {S_IDLE, S_PEND} drp_t;

   seq_t          seq_state, seq_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          ch30, ch30_next;
   logic          conv_done;

   logic [15:0]   g22, g30, s22, s30;
   logic [15:0]   g22_nx, g30_nx, noise;

   drp_t          drp_state, drp_next;
   logic [3:0]    lat, lat_next;
   logic          capture, protocol_err, drdy_next;
   logic [15:0]   rd_val, cap_val, snap;
   logic [15:0]   cfg0, cfg1, cfg2;

   assign g22_nx = g22 + RAMP_STEP;
   assign g30_nx = g30 + RAMP_STEP;

`ifdef XADC_RESP_NOISE_EN
   logic [15:0] lfsr;

   assign noise = {8'h00, lfsr[3:0], 4'h0};

   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN)
         lfsr <= 16'hACE1;
      else if (conv_done)
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end
`else
   assign noise = '0;
`endif

   // ---------------- conversion sequencer ----------------
   always_comb begin
      seq_next  = seq_state;
      cnt_next  = cnt;
      ch30_next = ch30;
      conv_done = 1'b0;
      unique case (seq_state)
         S_CONV: begin
            if (cnt == CNT_LAST) begin
               seq_next  = S_EOC;
               conv_done = 1'b1;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         S_EOC: begin
            seq_next  = S_CONV;
            cnt_next  = '0;
            ch30_next = ~ch30;
         end
         default: ;
      endcase
   end

   // Reset parks the sequencer in EOC of ch30 (flags themselves forced low),
   // so the first cycle after release is CONV of ch22.
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         seq_state   <= S_EOC;
         cnt         <= '0;
         ch30        <= 1'b1;
         busy_out    <= 1'b0;
         eoc_out     <= 1'b0;
         eos_out     <= 1'b0;
         channel_out <= '0;
         g22         <= 16'h0000;
         g30         <= 16'h8000;
         s22         <= '0;
         s30         <= '0;
      end else begin
         seq_state <= seq_next;
         cnt       <= cnt_next;
         ch30      <= ch30_next;
         busy_out  <= (seq_next == S_CONV);
         eoc_out   <= conv_done;
         eos_out   <= conv_done & ch30;
         if (conv_done) begin
            channel_out <= ch30 ? 5'h1E : 5'h16;
            if (ch30) begin
               g30 <= g30_nx;
               s30 <= g30_nx ^ noise;
            end else begin
               g22 <= g22_nx;
               s22 <= g22_nx ^ noise;
            end
         end
      end
   end

   // ---------------- DRP transaction FSM ----------------
   always_comb begin
      rd_val = '0;
      unique case (drp.daddr_in)
         7'h16:   rd_val = s22;
         7'h1E:   rd_val = s30;
         7'h40:   rd_val = cfg0;
         7'h41:   rd_val = cfg1;
         7'h42:   rd_val = cfg2;
         default: rd_val = '0;
      endcase
   end

   assign cap_val = drp.dwe_in ? 16'h0000 : rd_val;

   always_comb begin
      drp_next     = drp_state;
      lat_next     = lat;
      capture      = 1'b0;
      protocol_err = 1'b0;
      drdy_next    = 1'b0;
      unique case (drp_state)
         S_IDLE: begin
            if (drp.den_in) begin
               capture = 1'b1;
               if (DRDY_LAT == 1) begin
                  drdy_next = 1'b1;
               end else begin
                  drp_next = S_PEND;
                  lat_next = 4'd1;
               end
            end
         end
         S_PEND: begin
            protocol_err = drp.den_in;
            if (lat == LAT_LAST) begin
               drdy_next = 1'b1;
               drp_next  = S_IDLE;
            end else begin
               lat_next = lat + 4'd1;
            end
         end
         default: ;
      endcase
   end

   // The snapshot reads the sample registers before this edge's update,
   // so a same-cycle read/update collision returns the old value.
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         drp_state    <= S_IDLE;
         lat          <= '0;
         snap         <= '0;
         drp.do_out   <= '0;
         drp.drdy_out <= 1'b0;
         drp_err_out  <= 1'b0;
         cfg0         <= '0;
         cfg1         <= '0;
         cfg2         <= '0;
      end else begin
         drp_state    <= drp_next;
         lat          <= lat_next;
         drp.drdy_out <= drdy_next;
         if (capture)
            snap <= cap_val;
         if (drdy_next)
            drp.do_out <= (DRDY_LAT == 1) ? cap_val : snap;
         else
            drp.do_out <= '0;
         if (protocol_err)
            drp_err_out <= 1'b1;
         if (capture && drp.dwe_in) begin
            unique case (drp.daddr_in)
               7'h40:   cfg0 <= drp.di_in;
               7'h41:   cfg1 <= drp.di_in;
               7'h42:   cfg2 <= drp.di_in;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// -----------------------------------------------------------------------------
// tb_xadc_drp_responder
// Self-checking bench for xadc_drp_responder. A reference model derives the
// expected sequencer outputs and sample values from the cycle number since
// reset release; DRP responses come from a pending-transaction queue.
// A second instance with CONV_CYCLES=2 reaches the ch22 ramp wrap quickly.
// -----------------------------------------------------------------------------
module tb_xadc_drp_responder;

   localparam int PERIOD = 27;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;

   xadc_drp_responder_if bus ();
   xadc_drp_responder_if wbus ();

   logic       busy, eoc, eos, err;
   logic [4:0] chan;
   logic       w_busy, w_eoc, w_eos, w_err;
   logic [4:0] w_chan;

   xadc_drp_responder dut (
      .CLK100MHZ   (clk),
      .CPU_RESETN  (rst_n),
      .drp         (bus),
      .busy_out    (busy),
      .eoc_out     (eoc),
      .eos_out     (eos),
      .channel_out (chan),
      .drp_err_out (err)
   );

   xadc_drp_responder #(
      .CONV_CYCLES (2),
      .DRDY_LAT    (4),
      .RAMP_STEP   (16'h0010)
   ) dut_w (
      .CLK100MHZ   (clk),
      .CPU_RESETN  (rst_n),
      .drp         (wbus),
      .busy_out    (w_busy),
      .eoc_out     (w_eoc),
      .eos_out     (w_eos),
      .channel_out (w_chan),
      .drp_err_out (w_err)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit started  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   // cycle n = interval after the n-th clock edge with reset high
   always @(posedge clk) begin
      if (!rst_n) begin
         cyc     = 0;
         started = 1'b1;
      end else begin
         cyc = cyc + 1;
      end
   end

`ifdef XADC_RESP_NOISE_EN
   function automatic logic [15:0] lfsr_at(input int n);
      int l = 16'hACE1;
      int b;
      for (int i = 0; i < n; i++) begin
         b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
         l = (l >> 1) | (b << 15);
      end
      return 16'(l);
   endfunction
`endif

   // sample register value visible during cycle c for a conversion period p
   function automatic logic [15:0] exp_sample(input bit is30, input int c, input int p);
      int k = c / p;
      int n = is30 ? k / 2 : (k + 1) / 2;
      logic [15:0] v;
      if (n == 0) return 16'h0000;
      v = 16'((is30 ? 32'h8000 : 0) + n * 16);
`ifdef XADC_RESP_NOISE_EN
      v = v ^ 16'((lfsr_at(is30 ? 2 * n - 1 : 2 * (n - 1)) & 16'h000F) * 16);
`endif
      return v;
   endfunction

   typedef struct {
      int          due;
      logic [15:0] data;
   } pend_t;

   pend_t       q[$];
   bit          err_m = 1'b0;
   logic [15:0] cfg_m [3] = '{default: 16'h0000};

   function automatic logic [15:0] model_read(input logic [6:0] a, input int c);
      if (a == 7'h16) return exp_sample(1'b0, c, PERIOD);
      if (a == 7'h1E) return exp_sample(1'b1, c, PERIOD);
      if (a >= 7'h40 && a <= 7'h42) return cfg_m[a - 7'h40];
      return 16'h0000;
   endfunction

   // per-cycle reference model of the main instance
   always @(negedge clk) begin : mon
      int          k;
      bit          e_busy, e_eoc, e_eos, e_drdy;
      logic [4:0]  e_ch;
      pend_t       p;
      if (started) begin
         k      = cyc / PERIOD;
         e_busy = (cyc != 0) && (cyc % PERIOD != 0);
         e_eoc  = (cyc != 0) && (cyc % PERIOD == 0);
         e_eos  = e_eoc && (k % 2 == 0);
         e_ch   = (k == 0) ? 5'h00 : ((k % 2 == 1) ? 5'h16 : 5'h1E);
         chk("busy_out", 32'(busy), 32'(e_busy));
         chk("eoc_out", 32'(eoc), 32'(e_eoc));
         chk("eos_out", 32'(eos), 32'(e_eos));
         chk("channel_out", 32'(chan), 32'(e_ch));
         e_drdy = (q.size() > 0) && (q[0].due == cyc);
         chk("drdy_out", 32'(bus.drdy_out), 32'(e_drdy));
         if (e_drdy) begin
            p = q.pop_front();
            chk("do_out", 32'(bus.do_out), 32'(p.data));
         end
         chk("drp_err_out", 32'(err), 32'(err_m));
         if (!rst_n) begin
            q.delete();
            err_m = 1'b0;
            cfg_m = '{default: 16'h0000};
         end else if (bus.den_in) begin
            if (q.size() > 0) begin
               err_m = 1'b1;
            end else begin
               p.due  = cyc + 4;
               p.data = bus.dwe_in ? 16'h0000 : model_read(bus.daddr_in, cyc);
               if (bus.dwe_in && bus.daddr_in >= 7'h40 && bus.daddr_in <= 7'h42)
                  cfg_m[bus.daddr_in - 7'h40] = bus.di_in;
               q.push_back(p);
            end
         end
      end
   end

   // advance to #1 after the edge that starts cycle c
   task automatic goto(input int c);
      int guard = 0;
      while (cyc < c && guard < 40000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (cyc != c) chk("goto_bound", cyc, c);
   endtask

   task automatic drive(input logic [6:0] a, input logic we, input logic [15:0] d, input int c);
      goto(c);
      bus.daddr_in = a;
      bus.dwe_in   = we;
      bus.di_in    = d;
      bus.den_in   = 1'b1;
      goto(c + 1);
      bus.den_in   = 1'b0;
   endtask

   task automatic expect_at(input int c, input string name, input logic [15:0] e);
      goto(c);
      @(negedge clk);
      chk({name, "_drdy"}, 32'(bus.drdy_out), 32'd1);
      chk(name, 32'(bus.do_out), 32'(e));
   endtask

   typedef struct {
      logic [6:0]  addr;
      logic        we;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl [10];

   initial begin : watchdog
      #(60000 * 10);
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int cur, c;
      logic [6:0] ra;
      tbl[0] = '{7'h40, 1'b1, 16'hA5A5, 16'h0000};
      tbl[1] = '{7'h41, 1'b1, 16'hBEEF, 16'h0000};
      tbl[2] = '{7'h42, 1'b1, 16'h0F0F, 16'h0000};
      tbl[3] = '{7'h16, 1'b1, 16'h1234, 16'h0000};
      tbl[4] = '{7'h10, 1'b1, 16'hFFFF, 16'h0000};
      tbl[5] = '{7'h41, 1'b0, 16'h0000, 16'hBEEF};
      tbl[6] = '{7'h40, 1'b0, 16'h0000, 16'hA5A5};
      tbl[7] = '{7'h42, 1'b0, 16'h0000, 16'h0F0F};
      tbl[8] = '{7'h10, 1'b0, 16'h0000, 16'h0000};
      tbl[9] = '{7'h7F, 1'b0, 16'h0000, 16'h0000};

      bus.den_in = 1'b0;  bus.dwe_in = 1'b0;  bus.daddr_in = '0;  bus.di_in = '0;
      wbus.den_in = 1'b0; wbus.dwe_in = 1'b0; wbus.daddr_in = '0; wbus.di_in = '0;
      rst_n = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 32'({bus.do_out, bus.drdy_out, busy, eoc, eos, chan, err}), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      goto(1);
      @(negedge clk);
      chk("first_busy", 32'(busy), 32'd1);

      // read 0x16 on its update cycle, then again in the drdy cycle
      drive(7'h16, 1'b0, 16'h0, 26);
      @(negedge clk);
      chk("first_eoc", 32'(eoc), 32'd1);
      chk("first_eoc_chan", 32'(chan), 32'h16);
      goto(30);
      bus.daddr_in = 7'h16; bus.dwe_in = 1'b0; bus.den_in = 1'b1;
      @(negedge clk);
      chk("collision_drdy", 32'(bus.drdy_out), 32'd1);
      chk("collision_data", 32'(bus.do_out), 32'h0000);
      goto(31);
      bus.den_in = 1'b0;
      expect_at(34, "read_ch22", 16'h0010);

      goto(54);
      @(negedge clk);
      chk("second_eoc", 32'(eoc), 32'd1);
      chk("second_eos", 32'(eos), 32'd1);
      chk("second_chan", 32'(chan), 32'h1E);

      drive(7'h1E, 1'b0, 16'h0, 60);
      expect_at(64, "read_ch30", 16'h8010);

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].addr, tbl[i].we, tbl[i].wdata, 70 + 5 * i);
         expect_at(74 + 5 * i, $sformatf("tbl%0d", i), tbl[i].exp);
      end

      drive(7'h16, 1'b0, 16'h0, 120);
      expect_at(124, "ramp_after_write", exp_sample(1'b0, 120, PERIOD));

      // second den while pending
      drive(7'h40, 1'b0, 16'h0, 130);
      drive(7'h42, 1'b0, 16'h0, 132);
      expect_at(134, "viol_first", 16'hA5A5);
      goto(135);
      @(negedge clk);
      chk("viol_err", 32'(err), 32'd1);
      goto(136);
      @(negedge clk);
      chk("viol_no_second_drdy", 32'(bus.drdy_out), 32'd0);

      // randomized traffic, including back-to-back violations
      cur = 140;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 5))
            0:       ra = 7'h16;
            1:       ra = 7'h1E;
            2:       ra = 7'h40;
            3:       ra = 7'h41;
            4:       ra = 7'h42;
            default: ra = 7'($urandom);
         endcase
         drive(ra, 1'($urandom), 16'($urandom), cur);
         cur += $urandom_range(2, 7);
      end

      // reset mid-CONV with a read pending
      c = cur + 10;
      while (c % PERIOD != 10) c++;
      drive(7'h41, 1'b0, 16'h0, c - 2);
      goto(c);
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midreset_outputs", 32'({bus.do_out, bus.drdy_out, busy, eoc, eos, chan, err}), 32'd0);
      goto(2);
      @(negedge clk);
      chk("midreset_no_drdy", 32'(bus.drdy_out), 32'd0);
      chk("midreset_err_clear", 32'(err), 32'd0);
      goto(27);
      @(negedge clk);
      chk("midreset_eoc", 32'(eoc), 32'd1);
      chk("midreset_eoc_chan", 32'(chan), 32'h16);
      drive(7'h41, 1'b0, 16'h0, 30);
      expect_at(34, "cfg_after_reset", 16'h0000);

      // ch22 ramp wrap on the short-period instance (period 3)
      goto(24568);
      wbus.daddr_in = 7'h16; wbus.dwe_in = 1'b0; wbus.den_in = 1'b1;
      goto(24569);
      wbus.den_in = 1'b0;
      goto(24572);
      @(negedge clk);
      chk("wrap_pre_drdy", 32'(wbus.drdy_out), 32'd1);
      chk("wrap_pre", 32'(wbus.do_out), 32'(exp_sample(1'b0, 24568, 3)));
      goto(24576);
      wbus.den_in = 1'b1;
      goto(24577);
      wbus.den_in = 1'b0;
      goto(24580);
      @(negedge clk);
      chk("wrap_post_drdy", 32'(wbus.drdy_out), 32'd1);
      chk("wrap_post", 32'(wbus.do_out), 32'(exp_sample(1'b0, 24576, 3)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xadc_drp_responder.md
# xadc_drp_responder

Synthesizable stand-in for the XADC hard macro, acting as the responder on the DRP bus. It answers DRP reads and writes from the sensor-readout logic and sequences channel 22 (0x16) and channel 30 (0x1E) conversions. Each conversion produces deterministic ramp samples and pulses EOC/EOS. It lets the current-sensor path run on boards or in benches without analog inputs.

## Interface
- CONV_CYCLES, 26, busy cycles per conversion (≥2)
- DRDY_LAT, 4, cycles from accepted den_in to drdy_out (1..15)
- RAMP_STEP, 16'h0010, per-conversion sample increment (low nibble must be 0)
- CLK100MHZ  in  1  sole clock, DRP clock
- CPU_RESETN  in  1  synchronous, active-low reset
- daddr_in  in  7  DRP address
- den_in  in  1  DRP enable, 1-cycle strobe
- dwe_in  in  1  DRP write enable, qualified by den_in
- di_in  in  16  DRP write data
- do_out  out  16  DRP read data, valid when drdy_out=1
- drdy_out  out  1  DRP completion pulse
- busy_out  out  1  conversion in progress
- eoc_out  out  1  end-of-conversion pulse
- eos_out  out  1  end-of-sequence pulse (after ch30)
- channel_out  out  5  channel of the latest conversion
- drp_err_out  out  1  sticky: den_in seen while a transaction was pending

## Operation
- Register map:
  - 0x16: ch22 sample, read-only.
  - 0x1E: ch30 sample, read-only.
  - 0x40–0x42: config registers, read/write, stored only.
  - All other addresses read 0x0000; writes to them and to 0x16/0x1E are dropped.
- Sequencer states are CONV and EOC. Channels alternate 22, 30, 22, …
  - CONV lasts CONV_CYCLES cycles with busy_out=1.
  - The sample register updates on the last CONV cycle.
  - EOC lasts 1 cycle: busy_out=0, eoc_out=1, channel_out equals the converted channel, and eos_out=1 only when that channel is 30.
  - Then CONV for the other channel.
- Sample generation:
  - Per-channel 16-bit generator g. Seeds are ch22 0x0000 and ch30 0x8000.
  - At each conversion: g <= g + RAMP_STEP (mod 2^16), and the register <= new g.
  - Bits [3:0] are always 0 (12-bit left-justified format).
- DRP transaction FSM has states IDLE and PEND.
  - In IDLE, den_in=1 captures address, dwe_in and di_in. For a read it snapshots the register value in the capture cycle. It moves to PEND.
  - Writes commit in the capture cycle.
  - In PEND, a counter runs DRDY_LAT cycles. drdy_out then pulses 1 cycle and the FSM returns to IDLE.
  - For reads, do_out carries the snapshot. For writes, do_out = 0x0000.
  - den_in in PEND is ignored and sets drp_err_out. Only reset clears drp_err_out.
- Collision: if a read capture and a sample update to the same register occur in the same cycle, the read returns the pre-update value.
- A den_in in the drdy_out cycle is accepted (FSM already back in IDLE next cycle, capture on that den).

## Timing
- Reset (CPU_RESETN=0 on a clock edge) applies the following, regardless of state and aborting any pending transaction or conversion:
  - do_out=0, drdy_out=0, busy_out=0, eoc_out=0, eos_out=0, channel_out=0, drp_err_out=0.
  - Sample registers 0x0000, config registers 0x0000, generators at seeds.
- First cycle after reset release: CONV on ch22, busy_out=1.
- Conversion period is CONV_CYCLES+1. With default parameters:
  - First eoc_out at cycle 27 after release (release cycle = 1), channel_out=5'h16.
  - The next at cycle 54, channel_out=5'h1E with eos_out=1.
- DRP latency: den_in at cycle t gives drdy_out at t+DRDY_LAT. Minimum spacing between accepted transactions is DRDY_LAT cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- XADC_RESP_NOISE_EN defined:
  - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1; reset to seed), advanced once per conversion.
  - Stored sample = (g + RAMP_STEP) XOR {8'h00, lfsr[3:0], 4'h0}.
  - Generator g itself stays pure ramp.
- Undefined: no LFSR logic. Samples are pure ramp as above.

## Test plan
- Reset then idle with defaults: all outputs 0 during reset; busy_out=1 on cycle 1; eoc_out with channel_out=5'h16 on cycle 27; eos_out=1 on cycle 54 with channel 5'h1E.
- Read 0x16 after first EOC: den_in at t, address 0x16 → drdy_out at t+4, do_out=0x0010. Read 0x1E after second EOC → 0x8010.
- Write then read: write 0x41=0xBEEF → drdy_out at t+4 with do_out=0x0000. Read 0x41 → 0xBEEF. Write 0x16=0x1234 → later read 0x16 still returns the ramp value.
- Protocol violation: second den_in at t+2 → ignored, only one drdy_out at t+4, drp_err_out=1 until CPU_RESETN=0.
- Collision and wrap:
  - Read 0x16 captured on its update cycle → returns the previous value.
  - After 4096 ch22 conversions with RAMP_STEP=0x0010, ch22 wraps 0xFFF0→0x0000.
- Mid-operation reset: assert CPU_RESETN=0 during PEND and mid-CONV → no drdy_out, state as at reset, first EOC again 27 cycles after release. With XADC_RESP_NOISE_EN, bits [3:0] remain 0.
